// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants: default widths, reset PC, NOP encoding
// and the {pc, inst} entry carried from IF to ID.
package cpu_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_INST_W = 32;
  localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [DEF_INST_W-1:0] INST_NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO holding fetched {pc, inst} words; head reads 0 when empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             din,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is data only; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: credit-limited in-order memory requests, a response
// queue toward ID, and redirect with discard of stale in-flight responses.
module if_fetch_queue
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int INST_W = DEF_INST_W,
  parameter int DEPTH  = 4,
  parameter int MAX_OS = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [INST_W-1:0] mem_rdata_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OS) + 1;
  localparam int EW = ADDR_W + INST_W;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [OW-1:0]     outstanding;
  logic [OW-1:0]     discard;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic              credit_ok;
  logic              gnt_fire;
  logic              rsp_keep;
  logic              pop;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  // Every granted request owns a queue slot, so responses can never overflow.
  assign credit_ok  = (32'(outstanding) + 32'(count) < 32'(DEPTH)) &&
                      (32'(outstanding) < 32'(MAX_OS));
  assign mem_req_o  = rst && !flush_i && credit_ok;
  assign mem_addr_o = fetch_pc;
  assign gnt_fire   = mem_req_o && mem_gnt_i;
  assign rsp_keep   = mem_rvalid_i && (discard == '0) && !flush_i;
  assign id_valid_o = (count != '0) && !flush_i;
  assign pop        = id_valid_o && id_ready_i;
  assign id_pc_o    = head[EW-1:INST_W];
  assign id_inst_o  = head[INST_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (flush_i) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc    <= word_align(flush_pc_i);
      rsp_pc      <= word_align(flush_pc_i);
      outstanding <= outstanding - OW'(mem_rvalid_i);
      discard     <= outstanding - OW'(mem_rvalid_i);
    end else begin
      if (gnt_fire) fetch_pc <= fetch_pc + ADDR_W'(4);
      if (rsp_keep) rsp_pc   <= rsp_pc + ADDR_W'(4);
      outstanding <= outstanding + OW'(gnt_fire) - OW'(mem_rvalid_i);
      if (mem_rvalid_i && (discard != '0)) discard <= discard - OW'(1);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_keep),
    .pop   (pop),
    .clear (flush_i),
    .din   ({rsp_pc, mem_rdata_i}),
    .count (count),
    .head  (head)
  );
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed vector table, corner sequences, and a
// randomized run against a request/response queue model with stale tagging.
`timescale 1ns/1ps
module tb_if_fetch_queue;
  import cpu_pkg::*;

  localparam int DEPTH  = 4;
  localparam int MAX_OS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;

  always #5 clk = ~clk;

  if_fetch_queue #(
    .ADDR_W   (32),
    .INST_W   (32),
    .DEPTH    (DEPTH),
    .MAX_OS   (MAX_OS),
    .RESET_PC (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .flush_i      (flush_i),
    .flush_pc_i   (flush_pc_i),
    .id_valid_o   (id_valid_o),
    .id_ready_i   (id_ready_i),
    .id_pc_o      (id_pc_o),
    .id_inst_o    (id_inst_o)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          cyc;
    bit          stale;
  } mreq_t;

  mreq_t        memq[$];
  fetch_entry_t expq[$];
  logic [31:0]  popped[$];
  logic [31:0]  m_fetch_pc;
  int           cyc = 0;
  int           grants = 0;

  typedef struct {
    bit          gnt;
    bit          rvalid;
    logic [31:0] rsp_addr;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[8];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; flush_i = 1'b0; flush_pc_i = '0; id_ready_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    #1;
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_id_valid", 32'(id_valid_o), 32'd0);
    check("rst_id_pc", id_pc_o, 32'd0);
    check("rst_id_inst", id_inst_o, 32'd0);
    memq.delete(); expq.delete(); popped.delete();
    m_fetch_pc = 32'h0; grants = 0;
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  // One clock: drive inputs, compare against the model, then advance the model.
  task automatic step(input bit fl, input logic [31:0] fpc, input bit rdy,
                      input bit g, input bit r);
    bit    rv, m_req, has, pop;
    mreq_t m;
    @(negedge clk);
    rv = r && (memq.size() != 0) && (memq[0].cyc < cyc);
    flush_i = fl; flush_pc_i = fpc; id_ready_i = rdy; mem_gnt_i = g;
    mem_rvalid_i = rv;
    mem_rdata_i  = rv ? inst_of(memq[0].addr) : $urandom;
    #1;
    m_req = !fl && (memq.size() + expq.size() < DEPTH) && (memq.size() < MAX_OS);
    has   = !fl && (expq.size() != 0);
    check("mem_req", 32'(mem_req_o), 32'(m_req));
    if (m_req) check("mem_addr", mem_addr_o, m_fetch_pc);
    check("id_valid", 32'(id_valid_o), 32'(has));
    if (has) begin
      check("id_pc", id_pc_o, expq[0].pc);
      check("id_inst", id_inst_o, expq[0].inst);
    end else if (!fl) begin
      check("id_pc_empty", id_pc_o, 32'd0);
    end
    pop = has && rdy;
    if (pop) begin
      popped.push_back(id_pc_o);
      void'(expq.pop_front());
    end
    if (rv) begin
      m = memq.pop_front();
      if (!m.stale && !fl) expq.push_back('{pc: m.addr, inst: inst_of(m.addr)});
    end
    if (fl) begin
      foreach (memq[i]) memq[i].stale = 1'b1;
      expq.delete();
      m_fetch_pc = {fpc[31:2], 2'b00};
    end else if (mem_req_o && g) begin
      memq.push_back('{addr: m_fetch_pc, cyc: cyc, stale: 1'b0});
      m_fetch_pc = m_fetch_pc + 32'd4;
      grants++;
    end
    check("credit_invariant", 32'(memq.size() + expq.size() <= DEPTH), 32'd1);
    cyc++;
  endtask

  initial begin
    // gnt/rvalid pattern after reset release, incl. gnt withheld at 0x8
    tbl[0] = '{1, 0, 32'h0, 1, 32'h0, 0, 32'h0};
    tbl[1] = '{1, 1, 32'h0, 1, 32'h4, 0, 32'h0};
    tbl[2] = '{0, 1, 32'h4, 1, 32'h8, 1, 32'h0};
    tbl[3] = '{0, 0, 32'h0, 1, 32'h8, 1, 32'h4};
    tbl[4] = '{0, 0, 32'h0, 1, 32'h8, 0, 32'h0};
    tbl[5] = '{1, 0, 32'h0, 1, 32'h8, 0, 32'h0};
    tbl[6] = '{0, 1, 32'h8, 1, 32'hC, 0, 32'h0};
    tbl[7] = '{0, 0, 32'h0, 1, 32'hC, 1, 32'h8};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      flush_i = 1'b0; id_ready_i = 1'b1;
      mem_gnt_i = tbl[i].gnt; mem_rvalid_i = tbl[i].rvalid;
      mem_rdata_i = inst_of(tbl[i].rsp_addr);
      #1;
      check("tbl_req", 32'(mem_req_o), 32'(tbl[i].req));
      check("tbl_addr", mem_addr_o, tbl[i].addr);
      check("tbl_valid", 32'(id_valid_o), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        check("tbl_pc", id_pc_o, tbl[i].pc);
        check("tbl_inst", id_inst_o, inst_of(tbl[i].pc));
      end
    end

    // Back-to-back burst
    do_reset();
    repeat (8) step(0, 0, 1, 1, 1);
    check("burst_pops", 32'(popped.size() >= 5), 32'd1);
    for (int i = 0; i < popped.size() && i < 5; i++) check("burst_pc", popped[i], 32'(4 * i));

    // ID stall fills the queue, then drains in order
    do_reset();
    repeat (10) step(0, 0, 0, 1, 1);
    check("stall_grants", 32'(grants), 32'd4);
    check("stall_req_low", 32'(mem_req_o), 32'd0);
    repeat (6) step(0, 0, 1, 1, 1);
    check("stall_pops", 32'(popped.size() >= 4), 32'd1);
    for (int i = 0; i < popped.size() && i < 4; i++) check("stall_pc", popped[i], 32'(4 * i));

    // Flush with two requests outstanding; low address bits ignored
    do_reset();
    repeat (2) step(0, 0, 1, 1, 0);
    step(1, 32'h103, 1, 0, 0);
    popped.delete();
    repeat (8) step(0, 0, 1, 1, 1);
    check("flush_pops", 32'(popped.size() > 0), 32'd1);
    for (int i = 0; i < popped.size(); i++) check("flush_pc", popped[i], 32'h100 + 32'(4 * i));

    // Flush coinciding with rvalid, then a second flush while draining
    do_reset();
    repeat (3) step(0, 0, 1, 1, 0);
    step(1, 32'h180, 1, 0, 1);
    step(1, 32'h200, 1, 0, 0);
    popped.delete();
    repeat (8) step(0, 0, 1, 1, 1);
    check("drain_pops", 32'(popped.size() > 0), 32'd1);
    for (int i = 0; i < popped.size(); i++) check("drain_pc", popped[i], 32'h200 + 32'(4 * i));

    // Address wrap, then randomized traffic
    step(1, 32'hFFFF_FFF8, 1, 0, 1);
    repeat (12) step(0, 0, 1, 1, 1);
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
    end

    // Asynchronous reset between clock edges with a non-empty queue
    repeat (3) step(0, 0, 0, 1, 1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_mem_req", 32'(mem_req_o), 32'd0);
    check("arst_id_valid", 32'(id_valid_o), 32'd0);
    check("arst_id_pc", id_pc_o, 32'd0);
    check("arst_id_inst", id_inst_o, 32'd0);
    memq.delete(); expq.delete(); popped.delete();
    m_fetch_pc = 32'h0;
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (6) step(0, 0, 1, 1, 1);
    check("arst_pops", 32'(popped.size() > 0), 32'd1);
    for (int i = 0; i < popped.size(); i++) check("arst_pc", popped[i], 32'(4 * i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
